// File: rtl/friscv_h.sv
// Shared definitions for the friscv core: instruction bus sizing and AXI response codes.
package friscv_h;

    // Instruction bus
    localparam int unsigned INST_ADDR_W = 32;
    localparam int unsigned INST_DATA_W = 32;
    localparam int unsigned INST_ID_W   = 8;

    // AXI response codes
    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] EXOKAY = 2'b01;
    localparam logic [1:0] SLVERR = 2'b10;
    localparam logic [1:0] DECERR = 2'b11;

    // Response status for an access that did or did not decode to the RAM
    function automatic logic [1:0] axi_resp(input logic inrange);
        return inrange ? OKAY : SLVERR;
    endfunction

endpackage

// File: rtl/friscv_ram_1r1w.sv
// Single-port-read / single-port-write RAM with synchronous read and byte-enable write.
// Kept as a separate module so a technology macro can be dropped in.
module friscv_ram_1r1w #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 1024
) (
    input  logic                     clk_i,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] waddr_i,
    input  logic [WIDTH/8-1:0]       wbe_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic                     re_i,
    input  logic [$clog2(DEPTH)-1:0] raddr_i,
    output logic [WIDTH-1:0]         rdata_o
);

    localparam int unsigned NB = WIDTH / 8;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    // Byte-enabled write and registered read; a same-word read sees the pre-write contents
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            for (int i = 0; i < NB; i++) begin
                if (wbe_i[i]) begin
                    mem_q[waddr_i][i*8 +: 8] <= wdata_i[i*8 +: 8];
                end
            end
        end
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/friscv_axi_scratchpad.sv
// AXI4-lite slave in front of a word-addressed, byte-strobed scratchpad RAM.
// AW and W are buffered independently; a write commits once both are held and no
// response is pending. Reads complete one cycle after the AR handshake.
module friscv_axi_scratchpad
    import friscv_h::*;
#(
    parameter int unsigned          AXI_ADDR_W = 32,
    parameter int unsigned          AXI_ID_W   = 8,
    parameter int unsigned          AXI_DATA_W = 32,
    parameter int unsigned          DEPTH      = 1024,
    parameter logic [AXI_ADDR_W-1:0] BASE_ADDR  = '0
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    // write address
    input  logic                    awvalid,
    output logic                    awready,
    input  logic [AXI_ADDR_W-1:0]   awaddr,
    input  logic [2:0]              awprot,
    input  logic [AXI_ID_W-1:0]     awid,
    // write data
    input  logic                    wvalid,
    output logic                    wready,
    input  logic [AXI_DATA_W-1:0]   wdata,
    input  logic [AXI_DATA_W/8-1:0] wstrb,
    // write response
    output logic                    bvalid,
    input  logic                    bready,
    output logic [AXI_ID_W-1:0]     bid,
    output logic [1:0]              bresp,
    // read address
    input  logic                    arvalid,
    output logic                    arready,
    input  logic [AXI_ADDR_W-1:0]   araddr,
    input  logic [2:0]              arprot,
    input  logic [AXI_ID_W-1:0]     arid,
    // read data
    output logic                    rvalid,
    input  logic                    rready,
    output logic [AXI_ID_W-1:0]     rid,
    output logic [1:0]              rresp,
    output logic [AXI_DATA_W-1:0]   rdata
);

    localparam int unsigned NB   = AXI_DATA_W / 8;
    localparam int unsigned OFFW = $clog2(NB);
    localparam int unsigned IDXW = $clog2(DEPTH);

    localparam logic [AXI_ADDR_W:0] BASE_EXT = {1'b0, BASE_ADDR};
    localparam logic [AXI_ADDR_W:0] SPAN     = (AXI_ADDR_W+1)'(DEPTH * NB);

    // ------------------------------------------------------------------
    // Address decode. Offsets are one bit wider so a borrow flags addr < BASE_ADDR.
    // ------------------------------------------------------------------
    logic [AXI_ADDR_W:0] aw_off;
    logic [AXI_ADDR_W:0] ar_off;
    logic                aw_inrange;
    logic                ar_inrange;
    logic [IDXW-1:0]     aw_idx;
    logic [IDXW-1:0]     ar_idx;

    assign aw_off     = {1'b0, awaddr} - BASE_EXT;
    assign ar_off     = {1'b0, araddr} - BASE_EXT;
    assign aw_inrange = !aw_off[AXI_ADDR_W] && (aw_off < SPAN);
    assign ar_inrange = !ar_off[AXI_ADDR_W] && (ar_off < SPAN);
    assign aw_idx     = aw_off[OFFW +: IDXW];
    assign ar_idx     = ar_off[OFFW +: IDXW];

    // Protection bits are accepted but carry no meaning here
    logic unused_ok;
    assign unused_ok = ^{awprot, arprot, aw_off, ar_off};

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic                  aw_full_q, aw_full_d;
    logic [IDXW-1:0]       aw_idx_q, aw_idx_d;
    logic [AXI_ID_W-1:0]   aw_id_q, aw_id_d;
    logic                  aw_inr_q, aw_inr_d;

    logic                  w_full_q, w_full_d;
    logic [AXI_DATA_W-1:0] w_data_q, w_data_d;
    logic [NB-1:0]         w_strb_q, w_strb_d;

    logic                  b_valid_q, b_valid_d;
    logic [AXI_ID_W-1:0]   b_id_q, b_id_d;
    logic [1:0]            b_resp_q, b_resp_d;

    logic                  r_valid_q, r_valid_d;
    logic [AXI_ID_W-1:0]   r_id_q, r_id_d;
    logic [1:0]            r_resp_q, r_resp_d;
    logic                  r_inr_q, r_inr_d;

    logic                  aw_hs;
    logic                  w_hs;
    logic                  ar_hs;
    logic                  commit;
    logic [AXI_DATA_W-1:0] ram_rdata;

    assign awready = !aw_full_q;
    assign wready  = !w_full_q;
    assign arready = !r_valid_q || rready;

    assign aw_hs  = awvalid && awready;
    assign w_hs   = wvalid && wready;
    assign ar_hs  = arvalid && arready;
    // Hold off while a response is still waiting so B is never overwritten
    assign commit = aw_full_q && w_full_q && !b_valid_q;

    // Write holding registers: fill on their own handshake, drain together on commit
    always_comb begin
        aw_full_d = aw_full_q;
        aw_idx_d  = aw_idx_q;
        aw_id_d   = aw_id_q;
        aw_inr_d  = aw_inr_q;
        w_full_d  = w_full_q;
        w_data_d  = w_data_q;
        w_strb_d  = w_strb_q;
        if (commit) begin
            aw_full_d = 1'b0;
            w_full_d  = 1'b0;
        end
        if (aw_hs) begin
            aw_full_d = 1'b1;
            aw_idx_d  = aw_idx;
            aw_id_d   = awid;
            aw_inr_d  = aw_inrange;
        end
        if (w_hs) begin
            w_full_d = 1'b1;
            w_data_d = wdata;
            w_strb_d = wstrb;
        end
    end

    // Write response: raised by a commit, held until bready
    always_comb begin
        b_valid_d = b_valid_q;
        b_id_d    = b_id_q;
        b_resp_d  = b_resp_q;
        if (b_valid_q && bready) begin
            b_valid_d = 1'b0;
        end
        if (commit) begin
            b_valid_d = 1'b1;
            b_id_d    = aw_id_q;
            b_resp_d  = axi_resp(aw_inr_q);
        end
    end

    // Read response: loaded on the AR handshake, held until rready
    always_comb begin
        r_valid_d = r_valid_q && !rready;
        r_id_d    = r_id_q;
        r_resp_d  = r_resp_q;
        r_inr_d   = r_inr_q;
        if (ar_hs) begin
            r_valid_d = 1'b1;
            r_id_d    = arid;
            r_resp_d  = axi_resp(ar_inrange);
            r_inr_d   = ar_inrange;
        end
    end

    // Write-path registers
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            aw_full_q <= 1'b0;
            aw_idx_q  <= '0;
            aw_id_q   <= '0;
            aw_inr_q  <= 1'b0;
            w_full_q  <= 1'b0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
        end else begin
            aw_full_q <= aw_full_d;
            aw_idx_q  <= aw_idx_d;
            aw_id_q   <= aw_id_d;
            aw_inr_q  <= aw_inr_d;
            w_full_q  <= w_full_d;
            w_data_q  <= w_data_d;
            w_strb_q  <= w_strb_d;
        end
    end

    // Response-channel registers
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            b_valid_q <= 1'b0;
            b_id_q    <= '0;
            b_resp_q  <= OKAY;
            r_valid_q <= 1'b0;
            r_id_q    <= '0;
            r_resp_q  <= OKAY;
            r_inr_q   <= 1'b0;
        end else begin
            b_valid_q <= b_valid_d;
            b_id_q    <= b_id_d;
            b_resp_q  <= b_resp_d;
            r_valid_q <= r_valid_d;
            r_id_q    <= r_id_d;
            r_resp_q  <= r_resp_d;
            r_inr_q   <= r_inr_d;
        end
    end

    // Out-of-range reads leave the RAM idle; their data is forced to zero below
    friscv_ram_1r1w #(
        .WIDTH (AXI_DATA_W),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk_i   (aclk),
        .we_i    (commit && aw_inr_q),
        .waddr_i (aw_idx_q),
        .wbe_i   (w_strb_q),
        .wdata_i (w_data_q),
        .re_i    (ar_hs && ar_inrange),
        .raddr_i (ar_idx),
        .rdata_o (ram_rdata)
    );

    assign bvalid = b_valid_q;
    assign bid    = b_id_q;
    assign bresp  = b_resp_q;
    assign rvalid = r_valid_q;
    assign rid    = r_id_q;
    assign rresp  = r_resp_q;
    // RAM output only moves on an accepted in-range read, so this stays stable while stalled
    assign rdata  = r_inr_q ? ram_rdata : '0;

endmodule

// File: tb/tb_friscv_axi_scratchpad.sv
// Self-checking bench for friscv_axi_scratchpad: directed scenarios plus a random
// read/write mix checked against a byte-level memory model.
module tb_friscv_axi_scratchpad;

    localparam logic [31:0] LIMIT = 32'h0000_1000; // BASE 0 + 1024 words * 4 bytes

    logic        aclk = 1'b0;
    logic        aresetn;
    logic        awvalid, awready;
    logic [31:0] awaddr;
    logic [2:0]  awprot;
    logic [7:0]  awid;
    logic        wvalid, wready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        bvalid, bready;
    logic [7:0]  bid;
    logic [1:0]  bresp;
    logic        arvalid, arready;
    logic [31:0] araddr;
    logic [2:0]  arprot;
    logic [7:0]  arid;
    logic        rvalid, rready;
    logic [7:0]  rid;
    logic [1:0]  rresp;
    logic [31:0] rdata;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference memory: word contents plus a mask of bytes that have been written
    logic [31:0] mdl  [int];
    logic [31:0] mmsk [int];

    always #5 aclk = ~aclk;

    friscv_axi_scratchpad #(
        .AXI_ADDR_W (32),
        .AXI_ID_W   (8),
        .AXI_DATA_W (32),
        .DEPTH      (1024),
        .BASE_ADDR  (32'h0)
    ) dut (
        .aclk    (aclk),
        .aresetn (aresetn),
        .awvalid (awvalid),
        .awready (awready),
        .awaddr  (awaddr),
        .awprot  (awprot),
        .awid    (awid),
        .wvalid  (wvalid),
        .wready  (wready),
        .wdata   (wdata),
        .wstrb   (wstrb),
        .bvalid  (bvalid),
        .bready  (bready),
        .bid     (bid),
        .bresp   (bresp),
        .arvalid (arvalid),
        .arready (arready),
        .araddr  (araddr),
        .arprot  (arprot),
        .arid    (arid),
        .rvalid  (rvalid),
        .rready  (rready),
        .rid     (rid),
        .rresp   (rresp),
        .rdata   (rdata)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    function automatic logic [1:0] exp_resp(input logic [31:0] a);
        return (a < LIMIT) ? 2'b00 : 2'b10;
    endfunction

    task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        int w;
        logic [31:0] v;
        logic [31:0] m;
        if (a < LIMIT) begin
            w = int'(a >> 2);
            v = mdl.exists(w) ? mdl[w] : 32'h0;
            m = mmsk.exists(w) ? mmsk[w] : 32'h0;
            for (int i = 0; i < 4; i++) begin
                if (s[i]) begin
                    v[i*8 +: 8] = d[i*8 +: 8];
                    m[i*8 +: 8] = 8'hFF;
                end
            end
            mdl[w]  = v;
            mmsk[w] = m;
        end
    endtask

    task automatic send_aw(input logic [31:0] a, input logic [7:0] id);
        int t = 0;
        awvalid = 1'b1;
        awaddr  = a;
        awid    = id;
        while (!awready && t < 20) begin
            tick();
            t++;
        end
        chk("aw_accept", awready, 1);
        tick();
        awvalid = 1'b0;
    endtask

    task automatic send_w(input logic [31:0] d, input logic [3:0] s);
        int t = 0;
        wvalid = 1'b1;
        wdata  = d;
        wstrb  = s;
        while (!wready && t < 20) begin
            tick();
            t++;
        end
        chk("w_accept", wready, 1);
        tick();
        wvalid = 1'b0;
    endtask

    // gap > 0: W leads AW by gap cycles; gap < 0: AW leads W; 0: together
    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            input logic [7:0] id, input int gap);
        int t = 0;
        if (gap == 0) begin
            fork
                send_aw(a, id);
                send_w(d, s);
            join
        end else if (gap > 0) begin
            send_w(d, s);
            repeat (gap) begin
                chk("wready_low_while_held", wready, 0);
                tick();
            end
            send_aw(a, id);
        end else begin
            send_aw(a, id);
            repeat (-gap) begin
                chk("awready_low_while_held", awready, 0);
                tick();
            end
            send_w(d, s);
        end
        chk("b_not_early", bvalid, 0);
        tick();
        chk("b_latency", bvalid, 1);
        bready = 1'b1;
        while (!bvalid && t < 20) begin
            tick();
            t++;
        end
        chk("bid", bid, id);
        chk("bresp", bresp, exp_resp(a));
        tick();
        chk("b_retired", bvalid, 0);
        model_write(a, d, s);
    endtask

    task automatic do_read(input logic [31:0] a, input logic [7:0] id,
                           output logic [31:0] d, output logic [1:0] resp, output logic [7:0] ri);
        int t = 0;
        rready  = 1'b1;
        arvalid = 1'b1;
        araddr  = a;
        arid    = id;
        while (!arready && t < 20) begin
            tick();
            t++;
        end
        chk("ar_accept", arready, 1);
        tick();
        arvalid = 1'b0;
        chk("r_latency", rvalid, 1);
        d    = rdata;
        resp = rresp;
        ri   = rid;
        tick();
    endtask

    task automatic check_read(input logic [31:0] a, input logic [7:0] id);
        logic [31:0] d;
        logic [1:0]  resp;
        logic [7:0]  ri;
        int          w;
        do_read(a, id, d, resp, ri);
        w = int'(a >> 2);
        chk("rid", ri, id);
        chk("rresp", resp, exp_resp(a));
        if (a >= LIMIT) begin
            chk("rdata_oor_zero", d, 32'h0);
        end else if (mmsk.exists(w)) begin
            chk("rdata", d & mmsk[w], mdl[w] & mmsk[w]);
        end
    endtask

    initial begin
        logic [31:0] d;
        logic [1:0]  resp;
        logic [7:0]  ri;
        int          issued;
        int          got;
        int          cyc;
        logic        hold_v;
        logic [31:0] hold_d;
        logic [7:0]  hold_id;

        aresetn = 1'b0;
        awvalid = 1'b0; awaddr = '0; awprot = 3'b000; awid = '0;
        wvalid  = 1'b0; wdata  = '0; wstrb  = '0;
        bready  = 1'b1;
        arvalid = 1'b0; araddr = '0; arprot = 3'b000; arid = '0;
        rready  = 1'b1;
        repeat (3) tick();
        aresetn = 1'b1;

        // Reset state
        chk("rst_awready", awready, 1);
        chk("rst_wready", wready, 1);
        chk("rst_arready", arready, 1);
        chk("rst_bvalid", bvalid, 0);
        chk("rst_rvalid", rvalid, 0);
        chk("rst_bid", bid, 0);
        chk("rst_bresp", bresp, 0);
        chk("rst_rid", rid, 0);
        chk("rst_rresp", rresp, 0);
        chk("rst_rdata", rdata, 0);

        // Simple write then read
        do_write(32'h0, 32'h1234_5678, 4'hF, 8'h05, 0);
        do_write(32'h10, 32'hDEAD_BEEF, 4'hF, 8'h21, 0);
        do_read(32'h10, 8'h21, d, resp, ri);
        chk("first_rdata", d, 32'hDEAD_BEEF);
        chk("first_rresp", resp, 2'b00);
        chk("first_rid", ri, 8'h21);

        // W three cycles ahead of AW, single byte strobe
        do_write(32'h10, 32'h0000_00AA, 4'h1, 8'h22, 3);
        do_read(32'h10, 8'h23, d, resp, ri);
        chk("strobe_merge", d, 32'hDEAD_BEAA);

        // Just past the end of the RAM
        do_write(LIMIT, 32'hCAFE_F00D, 4'hF, 8'h33, 0);
        check_read(LIMIT, 8'h34);
        check_read(32'h0, 8'h35);

        // Response back-pressure: second write waits for the first B to retire
        bready = 1'b0;
        fork
            send_aw(32'h40, 8'h51);
            send_w(32'h1111_1111, 4'hF);
        join
        tick();
        chk("bp_first_b", bvalid, 1);
        chk("bp_first_bid", bid, 8'h51);
        fork
            send_aw(32'h44, 8'h52);
            send_w(32'h2222_2222, 4'hF);
        join
        repeat (3) begin
            tick();
            chk("bp_hold_valid", bvalid, 1);
            chk("bp_hold_bid", bid, 8'h51);
        end
        chk("bp_aw_stalled", awready, 0);
        bready = 1'b1;
        tick();
        chk("bp_first_retired", bvalid, 0);
        tick();
        chk("bp_second_b", bvalid, 1);
        chk("bp_second_bid", bid, 8'h52);
        chk("bp_second_bresp", bresp, 2'b00);
        tick();
        chk("bp_second_retired", bvalid, 0);
        model_write(32'h40, 32'h1111_1111, 4'hF);
        model_write(32'h44, 32'h2222_2222, 4'hF);
        check_read(32'h40, 8'h53);
        check_read(32'h44, 8'h54);

        // Back-to-back reads with rready toggling
        for (int i = 0; i < 8; i++) begin
            do_write(32'h80 + 32'(i * 4), $urandom, 4'hF, 8'(i), 0);
        end
        issued = 0;
        got    = 0;
        cyc    = 0;
        hold_v = 1'b0;
        hold_d = '0;
        hold_id = '0;
        while (got < 8 && cyc < 60) begin
            rready = (cyc % 2 == 0);
            if (issued < 8) begin
                arvalid = 1'b1;
                araddr  = 32'h80 + 32'(issued * 4);
                arid    = 8'h60 + 8'(issued);
            end else begin
                arvalid = 1'b0;
            end
            #1;
            chk("b2b_arready_rule", arready, !rvalid || rready);
            if (hold_v) begin
                chk("b2b_stable_valid", rvalid, 1);
                chk("b2b_stable_data", rdata, hold_d);
                chk("b2b_stable_id", rid, hold_id);
            end
            hold_v = 1'b0;
            if (rvalid && !rready) begin
                hold_v  = 1'b1;
                hold_d  = rdata;
                hold_id = rid;
            end
            if (rvalid && rready) begin
                chk("b2b_rid", rid, 8'h60 + 8'(got));
                chk("b2b_rdata", rdata, mdl[32 + got]);
                got++;
            end
            if (arvalid && arready) issued++;
            tick();
            cyc++;
        end
        arvalid = 1'b0;
        rready  = 1'b1;
        chk("b2b_count", got, 8);
        chk("b2b_issued", issued, 8);
        chk("b2b_no_dup", rvalid, 0);

        // Random mix against the model; low address bits are ignored by the DUT
        for (int n = 0; n < 40; n++) begin
            logic [31:0] a;
            if ($urandom_range(0, 9) == 0) begin
                a = LIMIT + 32'($urandom_range(0, 255) << 2);
            end else begin
                a = 32'($urandom_range(0, 63) << 2) | 32'($urandom_range(0, 3));
            end
            if ($urandom_range(0, 1) == 0) begin
                do_write(a, $urandom, 4'($urandom_range(0, 15)), 8'($urandom),
                         int'($urandom_range(0, 4)) - 2);
            end else begin
                check_read(a, 8'($urandom));
            end
        end

        // Reset while AW is held and W is empty
        do_write(32'h20, 32'h5A5A_5A5A, 4'hF, 8'h70, 0);
        send_aw(32'h20, 8'h71);
        chk("pre_rst_awready", awready, 0);
        chk("pre_rst_wready", wready, 1);
        aresetn = 1'b0;
        #3;
        chk("in_rst_awready", awready, 1);
        tick();
        aresetn = 1'b1;
        chk("post_rst_awready", awready, 1);
        chk("post_rst_wready", wready, 1);
        chk("post_rst_bvalid", bvalid, 0);
        chk("post_rst_rvalid", rvalid, 0);
        send_w(32'hFFFF_FFFF, 4'hF);
        repeat (3) begin
            chk("post_rst_no_commit", bvalid, 0);
            tick();
        end
        check_read(32'h20, 8'h72);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
